// File: rtl/stepper_move_ctrl.sv
// Full-step stepper move sequencer: per-move programmable step timer,
// two-phase-on coil drive and signed absolute position tracking.
module stepper_move_ctrl #(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned STEPS_W  = 16,
  parameter bit          HOLD_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [STEPS_W-1:0]  cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  input  logic                pos_clr,
  output logic [3:0]          coil,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [STEPS_W-1:0]  steps_left,
  output logic [31:0]         position
);
  localparam int unsigned POS_W = 32;
  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic                dir, dir_nxt;
  logic [PERIOD_W-1:0] period, period_nxt;
  logic [PERIOD_W-1:0] timer, timer_nxt;
  logic [1:0]          idx, idx_nxt;
  logic [POS_W-1:0]    position_nxt;
  logic [STEPS_W-1:0]  steps_left_nxt;
  logic                aborted_nxt;
  logic                cmd_ready_nxt, busy_nxt, done_nxt;
  logic [3:0]          coil_nxt;

  function automatic logic [3:0] phase_pattern(input logic [1:0] i);
    case (i)
      2'd0:    return 4'b0011;
      2'd1:    return 4'b0110;
      2'd2:    return 4'b1100;
      default: return 4'b1001;
    endcase
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      dir        <= 1'b0;
      period     <= '0;
      timer      <= '0;
      idx        <= 2'd0;
      position   <= '0;
      steps_left <= '0;
      aborted    <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      coil       <= HOLD_EN ? 4'b0011 : 4'b0000;
    end else begin
      state      <= state_nxt;
      dir        <= dir_nxt;
      period     <= period_nxt;
      timer      <= timer_nxt;
      idx        <= idx_nxt;
      position   <= position_nxt;
      steps_left <= steps_left_nxt;
      aborted    <= aborted_nxt;
      cmd_ready  <= cmd_ready_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      coil       <= coil_nxt;
    end
  end

  // Next state, step timing and output decode
  always_comb begin
    state_nxt      = state;
    dir_nxt        = dir;
    period_nxt     = period;
    timer_nxt      = timer;
    idx_nxt        = idx;
    position_nxt   = position;
    steps_left_nxt = steps_left;
    aborted_nxt    = aborted;

    case (state)
      IDLE: begin
        if (pos_clr) position_nxt = '0;
        if (cmd_valid) begin
          dir_nxt        = cmd_dir;
          period_nxt     = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
          timer_nxt      = period_nxt;
          steps_left_nxt = cmd_steps;
          aborted_nxt    = 1'b0;
          state_nxt      = (cmd_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Abort wins over a coincident step
        if (abort) begin
          aborted_nxt = 1'b1;
          state_nxt   = DONE;
        end else if (timer == PERIOD_W'(1)) begin
          timer_nxt      = period;
          idx_nxt        = dir ? idx + 2'd1 : idx - 2'd1;
          position_nxt   = dir ? position + POS_W'(1) : position - POS_W'(1);
          steps_left_nxt = steps_left - STEPS_W'(1);
          if (steps_left == STEPS_W'(1)) state_nxt = DONE;
        end else begin
          timer_nxt = timer - PERIOD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    cmd_ready_nxt = (state_nxt == IDLE);
    busy_nxt      = (state_nxt == RUN);
    done_nxt      = (state_nxt == DONE);
    coil_nxt      = (HOLD_EN || state_nxt != IDLE) ? phase_pattern(idx_nxt) : 4'b0000;
  end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Randomized bench for stepper_move_ctrl: per-cycle comparison against a
// schedule model (step count = elapsed cycles / period), hold and no-hold variants.
module tb_stepper_move_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [23:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic        pos_clr = 1'b0;

  logic        cmd_ready, busy, done, aborted;
  logic [3:0]  coil;
  logic [15:0] steps_left;
  logic [31:0] position;

  logic        cmd_ready_nh, busy_nh, done_nh, aborted_nh;
  logic [3:0]  coil_nh;
  logic [15:0] steps_left_nh;
  logic [31:0] position_nh;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pos = '0;
  int          m_idx = 0;

  always #5 clk = ~clk;

  stepper_move_ctrl #(.PERIOD_W(24), .STEPS_W(16), .HOLD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .abort(abort), .pos_clr(pos_clr), .coil(coil), .busy(busy), .done(done),
    .aborted(aborted), .steps_left(steps_left), .position(position)
  );

  stepper_move_ctrl #(.PERIOD_W(24), .STEPS_W(16), .HOLD_EN(1'b0)) dut_nh (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_nh),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .abort(abort), .pos_clr(pos_clr), .coil(coil_nh), .busy(busy_nh), .done(done_nh),
    .aborted(aborted_nh), .steps_left(steps_left_nh), .position(position_nh)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] pat(input int i);
    case (i & 3)
      0:       return 4'b0011;
      1:       return 4'b0110;
      2:       return 4'b1100;
      default: return 4'b1001;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_coil"}, 32'(coil), 32'h3);
    check({tag, "_coil_nohold"}, 32'(coil_nh), 32'h0);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_aborted"}, 32'(aborted), 32'd0);
    check({tag, "_steps_left"}, 32'(steps_left), 32'd0);
    check({tag, "_position"}, position, 32'd0);
  endtask

  // One move: t counts cycles after the accept edge; steps taken = t / P, capped.
  task automatic run_move(input logic d, input int n, input int per, input int t_a,
                          input logic clr);
    int p, send, smax, s, sg, guard;
    p     = (per < 2) ? 2 : per;
    send  = (t_a > 0) ? t_a : n * p;
    smax  = (t_a > 0) ? (t_a - 1) / p : n;
    guard = 0;
    while (!cmd_ready && guard < 200) begin
      tick();
      guard++;
    end
    check("ready_pre", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_steps  = 16'(n);
    cmd_period = 24'(per);
    pos_clr    = clr;
    abort      = 1'($urandom_range(0, 1));
    if (clr) m_pos = '0;
    tick();
    for (int t = 0; t <= send + 1; t++) begin
      s = t / p;
      if (s > smax) s = smax;
      sg = d ? s : -s;
      check("busy", 32'(busy), 32'(t < send));
      check("done", 32'(done), 32'(t == send));
      check("ready", 32'(cmd_ready), 32'(t > send));
      check("aborted", 32'(aborted), 32'((t_a > 0) && (t >= send)));
      check("steps_left", 32'(steps_left), 32'(n - s));
      check("position", position, m_pos + 32'(sg));
      check("coil", 32'(coil), 32'(pat(m_idx + sg)));
      check("coil_nohold", 32'(coil_nh), (t <= send) ? 32'(pat(m_idx + sg)) : 32'd0);
      if (t <= send) begin
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_dir    = 1'($urandom_range(0, 1));
        cmd_steps  = 16'($urandom);
        cmd_period = 24'($urandom);
        pos_clr    = 1'($urandom_range(0, 1));
        if (t + 1 <= send) abort = (t_a > 0) && (t + 1 == t_a);
        else               abort = 1'($urandom_range(0, 1));
        tick();
      end else begin
        cmd_valid = 1'b0;
        abort     = 1'b0;
        pos_clr   = 1'b0;
      end
    end
    m_pos = m_pos + 32'(d ? smax : -smax);
    m_idx = m_idx + (d ? smax : -smax);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int n, per, ta;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;
    tick();
    check_reset_values("reset_release");

    run_move(1'b1, 5, 10, 0, 1'b0);
    check("fwd_pos", position, 32'd5);
    run_move(1'b1, 3, 0, 0, 1'b0);
    run_move(1'b0, 3, 1, 0, 1'b1);
    check("rev_pos", position, 32'hFFFF_FFFD);
    check("rev_coil", 32'(coil), 32'h6);
    run_move(1'b1, 0, 7, 0, 1'b0);
    run_move(1'b1, 100, 4, 12, 1'b0);
    check("abort_steps_left", 32'(steps_left), 32'd98);
    check("abort_flag", 32'(aborted), 32'd1);

    pos_clr = 1'b1;
    tick();
    pos_clr = 1'b0;
    m_pos = '0;
    check("idle_pos_clr", position, 32'd0);

    for (int i = 0; i < 40; i++) begin
      n   = $urandom_range(0, 12);
      per = $urandom_range(0, 6);
      ta  = 0;
      if (n > 0 && $urandom_range(0, 3) == 0)
        ta = $urandom_range(1, n * ((per < 2) ? 2 : per));
      run_move(1'($urandom_range(0, 1)), n, per, ta, 1'($urandom_range(0, 3) == 0));
    end

    cmd_valid  = 1'b1;
    cmd_dir    = 1'b1;
    cmd_steps  = 16'd10;
    cmd_period = 24'd3;
    tick();
    cmd_valid = 1'b0;
    repeat (7) tick();
    check("midmove_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    check_reset_values("midmove_reset");
    rst   = 1'b1;
    m_pos = '0;
    m_idx = 0;
    tick();
    run_move(1'b1, 4, 3, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
